conv2d_frame_engine: RTL
========================

// Module: conv2d_frame_engine
// PURPOSE
//  Parametrised successor to the 8x8/3x3 convolution block: buffers one IMG_W x IMG_H frame,
//  convolves it with a run-time-loadable 3x3 kernel (valid region only), and streams the
//  (IMG_W-2)x(IMG_H-2) results row-major. Valid/ready handshakes on both sides. Sits between
//  the pixel RAM reader and the result writer.
// PARAMETERS
//  DATA_W     8   unsigned pixel width
//  COEF_W     8   unsigned kernel coefficient width
//  IMG_W      8   frame width in pixels (>=3)
//  IMG_H      8   frame height in pixels (>=3)
//  FRAC_BITS  7   coefficient fraction bits (128 = 1.0); used only with CONV_ROUND_SAT_EN
//  (local) ACC_W = DATA_W+COEF_W+4 accumulator/output width
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  coef_we    in   1       coefficient write strobe
//  coef_addr  in   4       coefficient index 0..8, row-major
//  coef_data  in   COEF_W  coefficient value
//  start      in   1       one-cycle pulse: begin a frame
//  din        in   DATA_W  input pixel
//  in_valid   in   1       din valid
//  in_ready   out  1       engine accepts din
//  dout       out  ACC_W   convolution result
//  out_valid  out  1       dout valid
//  out_ready  in   1       downstream accepts dout
//  busy       out  1       high from accepted start until frame_done
//  frame_done out  1       one-cycle pulse after last result accepted
// BEHAVIOUR
//  - Reset: in_ready=0, out_valid=0, dout=0, busy=0, frame_done=0, FSM=IDLE, counters=0;
//    kernel reverts to default {8,16,8, 16,32,16, 8,16,8}. Reset mid-frame discards the frame.
//  - FSM: IDLE -start-> LOAD -last pixel-> MUL -> SUM -> OUT -accepted, more-> MUL;
//    OUT -accepted, last-> DONE -> IDLE. start outside IDLE is ignored.
//  - LOAD: in_ready=1; pixel stored at index pix_cnt on in_valid&in_ready; pix_cnt 0..IMG_W*IMG_H-1;
//    after last pixel in_ready drops the next cycle.
//  - MUL: nine products window(r,c)[k]*coef[k] registered, unsigned, DATA_W+COEF_W bits each.
//  - SUM: nine products summed into ACC_W bits (no overflow possible); dout registered,
//    out_valid=1 on entry to OUT. Latency: first out_valid 2 cycles after leaving LOAD.
//  - OUT: dout and out_valid held stable until out_ready=1; transfer on out_valid&out_ready;
//    then c++ ; c wraps at IMG_W-3 to 0 with r++; last result at r=c=IMG_H-3/IMG_W-3.
//    Minimum 3 cycles per result.
//  - DONE: frame_done=1 one cycle, busy=0 the following cycle.
//  - Coefficient writes: applied only when FSM=IDLE; coef_we in any other state ignored;
//    coef_addr>8 ignored. Coefficients persist across frames.
//  - start and coef_we in same IDLE cycle: both take effect; new coefficient used by that frame.
// CONFIGURATION
//  - CONV_ROUND_SAT_EN defined: dout = min((sum + 2^(FRAC_BITS-1)) >> FRAC_BITS, 2^DATA_W-1),
//    zero-extended to ACC_W (round-half-up, saturate to pixel range).
//  - CONV_ROUND_SAT_EN undefined: dout = raw sum, full ACC_W precision.
// TESTING
//  1. Reset defaults, frame all 100 -> 36 results, each 12800 (macro: 100); frame_done once.
//  2. Ramp din=i (0..63) -> result(r,c)=128*(8r+c+9): first 1152, last 6912 (macro: 9, 54).
//  3. Hold out_ready=0 for 10 cycles at result 5 -> dout/out_valid stable, no result lost/duplicated.
//  4. Write identity kernel (coef4=1, others 0) in IDLE -> dout = centre pixel; coef_we
//     during LOAD -> ignored, results unchanged.
//  5. Macro on: all pixels 255, coef4=255 others 0 -> every dout=255 (saturated, raw 65025).
//  6. rst after 20 pixels in LOAD -> in_ready=0, busy=0, out_valid=0 immediately; default
//     kernel restored; following full frame gives test-1 results.

Source files
------------

// File: rtl/conv2d_frame_engine.sv
// Frame-buffered 3x3 convolution engine: loads an IMG_W x IMG_H frame, streams valid-region results.
// Optional rounding/saturation to pixel range is enabled with `define CONV_ROUND_SAT_EN.
module conv2d_frame_engine #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int FRAC_BITS = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_we,
  input  logic [3:0]                 coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       start,
  input  logic [DATA_W-1:0]          din,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W+COEF_W+3:0]   dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int ACC_W  = DATA_W + COEF_W + 4;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int PIX_AW = $clog2(NPIX);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int DEF_COEF [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SUM, S_OUT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [PIX_AW-1:0]   pix_cnt;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [DATA_W-1:0]   pix_mem [NPIX];
  logic [COEF_W-1:0]   coef [9];
  logic [PROD_W-1:0]   prod [9];
  logic [PIX_AW-1:0]   win_addr [9];
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    dout_nxt;
  logic                in_fire, out_fire, last_pix, last_col, last_row;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_pix = (pix_cnt == PIX_AW'(NPIX - 1));
  assign last_col = (col == COL_W'(IMG_W - 3));
  assign last_row = (row == ROW_W'(IMG_H - 3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: if (in_fire && last_pix) state_nxt = S_MUL;
      S_MUL:  state_nxt = S_SUM;
      S_SUM:  state_nxt = S_OUT;
      S_OUT:  if (out_fire) state_nxt = (last_row && last_col) ? S_DONE : S_MUL;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_LOAD);
    out_valid  = (state == S_OUT);
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
  end

  // Pixel write pointer and output window position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        pix_cnt <= '0;
        row     <= '0;
        col     <= '0;
      end
      if (in_fire) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      if (state == S_OUT && out_fire) begin
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) pix_mem[pix_cnt] <= din;
  end

  // Kernel is only writable while idle so a running frame always sees one kernel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) coef[k] <= COEF_W'(DEF_COEF[k]);
    end else if (state == S_IDLE && coef_we && coef_addr <= 4'd8) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++)
      win_addr[k] = PIX_AW'((int'(row) + k / 3) * IMG_W + int'(col) + k % 3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) prod[k] <= '0;
    end else if (state == S_MUL) begin
      for (int k = 0; k < 9; k++)
        prod[k] <= PROD_W'(pix_mem[win_addr[k]]) * PROD_W'(coef[k]);
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) sum = sum + ACC_W'(prod[k]);
  end

`ifdef CONV_ROUND_SAT_EN
  localparam logic [ACC_W:0] PIX_MAX = (ACC_W+1)'((2 ** DATA_W) - 1);
  localparam logic [ACC_W:0] HALF    = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
  logic [ACC_W:0] rnd, shifted;
  always_comb begin
    rnd      = {1'b0, sum} + HALF;
    shifted  = rnd >> FRAC_BITS;
    dout_nxt = (shifted > PIX_MAX) ? PIX_MAX[ACC_W-1:0] : shifted[ACC_W-1:0];
  end
`else
  assign dout_nxt = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                dout <= '0;
    else if (state == S_SUM) dout <= dout_nxt;
  end

endmodule
